// File: rtl/fb_pkg.sv
// Shared definitions for the 1-bpp 160x120 frame buffer.
// Holds the address geometry, the controller state encoding and the pixel
// address field layout {Y[6:0], X[7:0]}.
package fb_pkg;

    localparam int unsigned FB_ADDR_W    = 15;
    localparam int unsigned FB_X_W       = 8;
    localparam int unsigned FB_Y_W       = 7;
    localparam int unsigned FB_X_VISIBLE = 160;
    localparam int unsigned FB_Y_VISIBLE = 120;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } fb_state_e;

    // Pixel address fields; the row sits above the column.
    typedef struct packed {
        logic [FB_Y_W-1:0] y;
        logic [FB_X_W-1:0] x;
    } fb_pix_addr_t;

endpackage

// File: rtl/frame_buffer_ctrl_if.sv
// Bundle of the VGA read port, host write port and clear-engine handshake.
// master: VGA generator / host side. slave: frame_buffer_ctrl.
// With FB_READBACK_EN defined the host readback bit HOST_RDATA is present.
interface frame_buffer_ctrl_if;
    import fb_pkg::*;

    logic [FB_ADDR_W-1:0] VGA_ADDR;
    logic                 VGA_RD_EN;
    logic                 VGA_DATA;
    logic [FB_ADDR_W-1:0] HOST_ADDR;
    logic                 HOST_WDATA;
    logic                 HOST_WE;
    logic                 HOST_READY;
    logic                 CLEAR_REQ;
    logic                 CLEAR_VALUE;
    logic                 CLEAR_BUSY;
    logic                 CLEAR_DONE;
`ifdef FB_READBACK_EN
    logic                 HOST_RDATA;
`endif

    modport master (
        output VGA_ADDR, VGA_RD_EN, HOST_ADDR, HOST_WDATA, HOST_WE,
               CLEAR_REQ, CLEAR_VALUE,
`ifdef FB_READBACK_EN
        input  HOST_RDATA,
`endif
        input  VGA_DATA, HOST_READY, CLEAR_BUSY, CLEAR_DONE
    );

    modport slave (
        input  VGA_ADDR, VGA_RD_EN, HOST_ADDR, HOST_WDATA, HOST_WE,
               CLEAR_REQ, CLEAR_VALUE,
`ifdef FB_READBACK_EN
        output HOST_RDATA,
`endif
        output VGA_DATA, HOST_READY, CLEAR_BUSY, CLEAR_DONE
    );

endinterface

// File: rtl/fb_dpram.sv
// Simple dual-port 2^ADDR_W x 1 RAM, single clock, read-first on both ports.
// Port A: write, plus a read with enable when FB_READBACK_EN is defined.
// Port B: read-only with enable.
// Ports: clk_i, rst_i (clears only the output registers), we_a_i, addr_a_i,
//        wdata_a_i, [rd_en_a_i, rdata_a_o], rd_en_b_i, addr_b_i, rdata_b_o.
module fb_dpram #(
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_a_i,
    input  logic [ADDR_W-1:0] addr_a_i,
    input  logic              wdata_a_i,
`ifdef FB_READBACK_EN
    input  logic              rd_en_a_i,
    output logic              rdata_a_o,
`endif
    input  logic              rd_en_b_i,
    input  logic [ADDR_W-1:0] addr_b_i,
    output logic              rdata_b_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    // Array contents are never reset so this maps onto block RAM.
    logic mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_a_i) begin
            mem_q[addr_a_i] <= wdata_a_i;
        end
    end

    // Port B read register; non-blocking update gives read-first behaviour.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_b_o <= 1'b0;
        end else if (rd_en_b_i) begin
            rdata_b_o <= mem_q[addr_b_i];
        end
    end

`ifdef FB_READBACK_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_a_o <= 1'b0;
        end else if (rd_en_a_i) begin
            rdata_a_o <= mem_q[addr_a_i];
        end
    end
`endif

endmodule

// File: rtl/frame_buffer_ctrl.sv
// 1-bpp 160x120 frame buffer feeding the VGA generator.
// Contains the clear FSM and counter, the visible-area range check for host
// writes and the RAM write-port mux (clear engine has priority over host).
// Ports: CLK, RESET (synchronous, active high), bus (frame_buffer_ctrl_if.slave):
//   VGA_ADDR/VGA_RD_EN -> VGA_DATA (1-cycle read), HOST_ADDR/HOST_WDATA/HOST_WE
//   -> HOST_READY, CLEAR_REQ/CLEAR_VALUE -> CLEAR_BUSY/CLEAR_DONE.
// Optional feature macro FB_READBACK_EN adds host reads on HOST_RDATA.
module frame_buffer_ctrl
    import fb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = FB_ADDR_W,
    parameter int unsigned X_VISIBLE  = FB_X_VISIBLE,
    parameter int unsigned Y_VISIBLE  = FB_Y_VISIBLE
) (
    input  logic               CLK,
    input  logic               RESET,
    frame_buffer_ctrl_if.slave bus
);

    fb_state_e             state_q;
    logic [ADDR_WIDTH-1:0] clr_cnt_q;
    logic                  clr_val_q;

    logic                  host_ready_c;
    logic                  in_range_c;
    fb_pix_addr_t          host_pix_c;
    logic                  ram_we_c;
    logic [ADDR_WIDTH-1:0] ram_addr_c;
    logic                  ram_wdata_c;

    // A pending clear request blocks the host beat in the same cycle.
    assign host_ready_c   = (state_q == IDLE) && !bus.CLEAR_REQ;
    assign bus.HOST_READY = host_ready_c;
    assign bus.CLEAR_BUSY = (state_q == CLEAR);
    assign bus.CLEAR_DONE = (state_q == DONE);

    // Off-screen host writes still handshake but never reach the RAM.
    assign host_pix_c = fb_pix_addr_t'(bus.HOST_ADDR);
    assign in_range_c = (host_pix_c.x < FB_X_W'(X_VISIBLE)) &&
                        (host_pix_c.y < FB_Y_W'(Y_VISIBLE));

    // Clear FSM: the counter walks every address once, including off-screen ones.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
            clr_val_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.CLEAR_REQ) begin
                        state_q   <= CLEAR;
                        clr_cnt_q <= '0;
                        clr_val_q <= bus.CLEAR_VALUE;
                    end
                end
                CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
                    if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // RAM port A mux: clear engine first, otherwise accepted in-range host beats.
    always_comb begin
        ram_we_c    = bus.HOST_WE && host_ready_c && in_range_c;
        ram_addr_c  = bus.HOST_ADDR;
        ram_wdata_c = bus.HOST_WDATA;
        if (state_q == CLEAR) begin
            ram_we_c    = 1'b1;
            ram_addr_c  = clr_cnt_q;
            ram_wdata_c = clr_val_q;
        end
    end

`ifdef FB_READBACK_EN
    logic host_rd_c;
    assign host_rd_c = !bus.HOST_WE && host_ready_c;
`endif

    fb_dpram #(
        .ADDR_W (ADDR_WIDTH)
    ) u_ram (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .we_a_i    (ram_we_c),
        .addr_a_i  (ram_addr_c),
        .wdata_a_i (ram_wdata_c),
`ifdef FB_READBACK_EN
        .rd_en_a_i (host_rd_c),
        .rdata_a_o (bus.HOST_RDATA),
`endif
        .rd_en_b_i (bus.VGA_RD_EN),
        .addr_b_i  (bus.VGA_ADDR),
        .rdata_b_o (bus.VGA_DATA)
    );

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Self-checking bench for frame_buffer_ctrl: directed cases plus randomized
// host/VGA traffic compared against an array model of the pixel memory.
module tb_frame_buffer_ctrl;

    localparam int unsigned NPIX = 32768;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frame_buffer_ctrl_if bus ();

    frame_buffer_ctrl dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    // Reference memory and a flag telling whether each pixel's value is known.
    bit mdl   [NPIX];
    bit known [NPIX];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] pa(input int unsigned y, input int unsigned x);
        return {7'(y), 8'(x)};
    endfunction

    function automatic bit visible(input logic [14:0] a);
        int unsigned x, y;
        x = int'(a) % 256;
        y = int'(a) / 256;
        return (x < 160) && (y < 120);
    endfunction

    task automatic idle_inputs();
        bus.VGA_ADDR    = '0;
        bus.VGA_RD_EN   = 1'b0;
        bus.HOST_ADDR   = '0;
        bus.HOST_WDATA  = 1'b0;
        bus.HOST_WE     = 1'b0;
        bus.CLEAR_REQ   = 1'b0;
        bus.CLEAR_VALUE = 1'b0;
    endtask

    // One accepted host write; model updated only for visible pixels.
    task automatic host_write(input string tag, input logic [14:0] a, input bit d);
        bus.HOST_ADDR  = a;
        bus.HOST_WDATA = d;
        bus.HOST_WE    = 1'b1;
        @(negedge clk);
        chk({tag, "_ready"}, 32'(bus.HOST_READY), 32'd1);
        cyc();
        bus.HOST_WE = 1'b0;
        if (visible(a)) begin
            mdl[a]   = d;
            known[a] = 1'b1;
        end
    endtask

    task automatic vga_read(input string tag, input logic [14:0] a, input bit exp);
        bus.VGA_ADDR  = a;
        bus.VGA_RD_EN = 1'b1;
        cyc();
        bus.VGA_RD_EN = 1'b0;
        chk(tag, 32'(bus.VGA_DATA), 32'(exp));
    endtask

    // Full clear; caller may already be driving HOST_WE, which must be refused.
    task automatic do_clear(input bit val);
        int unsigned busy_cnt  = 0;
        int unsigned ready_bad = 0;
        int unsigned k;
        logic [14:0] a;
        bit          rd;
        bus.CLEAR_REQ   = 1'b1;
        bus.CLEAR_VALUE = val;
        @(negedge clk);
        chk("ready_at_req", 32'(bus.HOST_READY), 32'd0);
        cyc();
        bus.CLEAR_REQ = 1'b0;
        bus.HOST_WE   = 1'b0;
        while (bus.CLEAR_BUSY === 1'b1 && busy_cnt < 40000) begin
            busy_cnt++;
            k = busy_cnt - 1;
            // A second request mid-clear with the other value must be ignored.
            bus.CLEAR_REQ   = (busy_cnt == 5000);
            bus.CLEAR_VALUE = ~val;
            rd = (busy_cnt % 61 == 7);
            a  = 15'($urandom);
            bus.VGA_ADDR  = a;
            bus.VGA_RD_EN = rd;
            @(negedge clk);
            if (bus.HOST_READY !== 1'b0) ready_bad++;
            cyc();
            // Pixel k is written on this edge; lower addresses already hold val.
            if (rd && (int'(a) < int'(k) || known[a]))
                chk("clear_rd", 32'(bus.VGA_DATA), (int'(a) < int'(k)) ? 32'(val) : 32'(mdl[a]));
        end
        bus.CLEAR_REQ = 1'b0;
        bus.VGA_RD_EN = 1'b0;
        chk("busy_len", busy_cnt, 32'd32768);
        chk("ready_in_clear", ready_bad, 32'd0);
        chk("done_pulse", 32'(bus.CLEAR_DONE), 32'd1);
        cyc();
        chk("done_once", 32'(bus.CLEAR_DONE), 32'd0);
        chk("idle_ready", 32'(bus.HOST_READY), 32'd1);
        for (int i = 0; i < int'(NPIX); i++) begin
            mdl[i]   = val;
            known[i] = 1'b1;
        end
    endtask

    // Randomized traffic: host writes (on and off screen) with concurrent VGA reads.
    task automatic random_traffic(input int n);
        bit          we, wd, rd;
        logic [14:0] wa, ra;
        bit          exp_vga;
        int unsigned ready_bad = 0;
`ifdef FB_READBACK_EN
        bit exp_rb;
        exp_rb = bus.HOST_RDATA;
`endif
        exp_vga = bus.VGA_DATA;
        for (int i = 0; i < n; i++) begin
            we = 1'($urandom);
            wd = 1'($urandom);
            wa = ($urandom % 4 == 0) ? 15'($urandom)
                                     : pa($urandom % 120, $urandom % 160);
            rd = ($urandom % 3 != 0);
            ra = ($urandom % 3 == 0) ? wa : 15'($urandom);
            bus.HOST_ADDR  = wa;
            bus.HOST_WDATA = wd;
            bus.HOST_WE    = we;
            bus.VGA_ADDR   = ra;
            bus.VGA_RD_EN  = rd;
            @(negedge clk);
            if (bus.HOST_READY !== 1'b1) ready_bad++;
            cyc();
            if (rd) exp_vga = mdl[ra];
            chk("rand_vga", 32'(bus.VGA_DATA), 32'(exp_vga));
`ifdef FB_READBACK_EN
            if (!we) exp_rb = mdl[wa];
            chk("rand_rdata", 32'(bus.HOST_RDATA), 32'(exp_rb));
`endif
            if (we && visible(wa)) mdl[wa] = wd;
        end
        bus.HOST_WE   = 1'b0;
        bus.VGA_RD_EN = 1'b0;
        chk("rand_ready", ready_bad, 32'd0);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned done_seen;
        idle_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        chk("rst_vga_data", 32'(bus.VGA_DATA), 32'd0);
        chk("rst_busy", 32'(bus.CLEAR_BUSY), 32'd0);
        chk("rst_done", 32'(bus.CLEAR_DONE), 32'd0);
`ifdef FB_READBACK_EN
        chk("rst_rdata", 32'(bus.HOST_RDATA), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(bus.HOST_READY), 32'd1);
        cyc();

        // Bring memory to a known state.
        do_clear(1'b0);

        host_write("wr_5_3", pa(3, 5), 1'b1);
        vga_read("rd_5_3", pa(3, 5), 1'b1);
        host_write("wr_x160", pa(0, 160), 1'b1);
        vga_read("rd_x160", pa(0, 160), 1'b0);
        host_write("wr_y120", pa(120, 0), 1'b1);
        vga_read("rd_y120", pa(120, 0), 1'b0);
        host_write("wr_x159_y119", pa(119, 159), 1'b1);
        vga_read("rd_x159_y119", pa(119, 159), 1'b1);

        // Same-address write 0 over 1 with a concurrent read: old bit first.
        host_write("wr_col1", pa(10, 20), 1'b1);
        bus.HOST_ADDR  = pa(10, 20);
        bus.HOST_WDATA = 1'b0;
        bus.HOST_WE    = 1'b1;
        bus.VGA_ADDR   = pa(10, 20);
        bus.VGA_RD_EN  = 1'b1;
        cyc();
        bus.HOST_WE = 1'b0;
        mdl[pa(10, 20)] = 1'b0;
        chk("col_old", 32'(bus.VGA_DATA), 32'd1);
        cyc();
        chk("col_new", 32'(bus.VGA_DATA), 32'd0);
        bus.VGA_RD_EN = 1'b0;
        bus.VGA_ADDR  = pa(3, 5);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rd_en_hold", 32'(bus.VGA_DATA), 32'd0);
        end

        random_traffic(400);

        // Clear to 1 while the host tries to write 0 to a pixel still holding 1.
        host_write("pre_clr", pa(3, 5), 1'b1);
        bus.HOST_ADDR  = pa(3, 5);
        bus.HOST_WDATA = 1'b0;
        bus.HOST_WE    = 1'b1;
        do_clear(1'b1);
        for (int i = 0; i < 16; i++) vga_read("post_clr", 15'($urandom), 1'b1);
        vga_read("post_clr_5_3", pa(3, 5), 1'b1);

        random_traffic(200);

        // Reset partway through a clear.
        bus.CLEAR_REQ   = 1'b1;
        bus.CLEAR_VALUE = 1'b0;
        cyc();
        bus.CLEAR_REQ = 1'b0;
        for (int i = 0; i < 1000; i++) cyc();
        chk("abort_busy_before", 32'(bus.CLEAR_BUSY), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("abort_busy", 32'(bus.CLEAR_BUSY), 32'd0);
        chk("abort_done", 32'(bus.CLEAR_DONE), 32'd0);
        @(negedge clk);
        chk("abort_ready", 32'(bus.HOST_READY), 32'd1);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (bus.CLEAR_DONE !== 1'b0 || bus.CLEAR_BUSY !== 1'b0) done_seen++;
        end
        chk("abort_quiet", done_seen, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
